rr_run_detect_arbiter: RTL and testbench



---
 rtl/rr_run_detect_arbiter_if.sv | 26 ++
 rtl/rr_run_detect_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_run_detect_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_run_detect_arbiter_if.sv
// Request/grant/detect bundle between N serial-bit requesters and the
// shared run-of-ones detector arbiter.
interface rr_run_detect_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  REQ;
    logic [N-1:0]  X;
    logic [N-1:0]  GNT;
    logic [OW-1:0] OWNER;
    logic          BUSY;
    logic [N-1:0]  DET;

    // Requester side drives requests and serial bits.
    modport master (
        output REQ, X,
        input  GNT, OWNER, BUSY, DET
    );

    // Arbiter side.
    modport slave (
        input  REQ, X,
        output GNT, OWNER, BUSY, DET
    );
endinterface

// File: rtl/rr_run_detect_arbiter.sv
// Round-robin arbiter sharing one run-of-ones detector among N serial
// requesters. The owner streams bits on its X lane; RUN_LEN consecutive 1s
// raise that owner's DET bit. FSM: IDLE -> OWN -> FLUSH -> IDLE.
// Optional build macro ARB_BURST_LIMIT_EN: force release after MAX_BURST
// samples in one grant; when undefined the owner keeps the grant until its
// REQ drops.
module rr_run_detect_arbiter #(
    parameter int N         = 4,
    parameter int RUN_LEN   = 3,
    parameter int MAX_BURST = 16
) (
    input logic CLK,
    input logic RST,
    rr_run_detect_arbiter_if.slave bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [RW-1:0] RL   = RW'(RUN_LEN);
    localparam logic [BW-1:0] MB   = BW'(MAX_BURST);
    localparam logic [OW-1:0] LAST = OW'(N - 1);

    typedef enum logic [1:0] {IDLE, OWN, FLUSH} state_t;

    state_t        state, state_n;
    logic [N-1:0]  gnt, gnt_n;
    logic [N-1:0]  det, det_n;
    logic [OW-1:0] owner, owner_n;
    logic [OW-1:0] ptr, ptr_n;
    logic [RW-1:0] run, run_n;
    logic [BW-1:0] burst, burst_n;

    logic [OW-1:0] sel, idx;
    logic          found;

    // Round-robin pick: first requester strictly after ptr, wrapping.
    always_comb begin
        sel   = '0;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (idx == LAST) ? '0 : idx + OW'(1);
            if (!found && bus.REQ[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Next-state, grant, run/burst counting and detection.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        det_n   = det;
        owner_n = owner;
        ptr_n   = ptr;
        run_n   = run;
        burst_n = burst;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = OWN;
                    gnt_n        = '0;
                    gnt_n[sel]   = 1'b1;
                    owner_n      = sel;
                    det_n        = '0;
                    run_n        = '0;
                    burst_n      = '0;
                end
            end
            OWN: begin
                if (!bus.REQ[owner]) begin
                    state_n = FLUSH;
                    gnt_n   = '0;
                    det_n   = '0;
                    run_n   = '0;
                    burst_n = '0;
                end else begin
                    // Run saturates at RUN_LEN so a long run never wraps.
                    if (bus.X[owner])
                        run_n = (run == RL) ? run : run + RW'(1);
                    else
                        run_n = '0;
                    // Saturating so the no-limit build never wraps either.
                    burst_n = (burst == MB) ? burst : burst + BW'(1);
                    det_n   = '0;
                    if (run_n == RL)
                        det_n[owner] = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
                    // The sample just taken was the last one this grant allows.
                    if (burst_n == MB) begin
                        state_n = FLUSH;
                        gnt_n   = '0;
                        det_n   = '0;
                        run_n   = '0;
                        burst_n = '0;
                    end
`endif
                end
            end
            FLUSH: begin
                // Releasing owner becomes lowest priority next round.
                state_n = IDLE;
                ptr_n   = owner;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset gives requester 0 first priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= '0;
            det   <= '0;
            owner <= '0;
            ptr   <= LAST;
            run   <= '0;
            burst <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            det   <= det_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            run   <= run_n;
            burst <= burst_n;
        end
    end

    assign bus.GNT   = gnt;
    assign bus.DET   = det;
    assign bus.OWNER = owner;
    assign bus.BUSY  = (state != IDLE);
endmodule

// File: tb/tb_rr_run_detect_arbiter.sv
// Directed bench for rr_run_detect_arbiter (N=4, RUN_LEN=3, MAX_BURST=16).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_rr_run_detect_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    rr_run_detect_arbiter_if #(.N(4)) bus ();

    rr_run_detect_arbiter #(.N(4), .RUN_LEN(3), .MAX_BURST(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        bus.REQ = 4'b0000;
        bus.X   = 4'b0000;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.REQ = 4'b0000;
        bus.X   = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] xs [6];
    logic [3:0] ds [6];

    initial begin
        // Reset with everything asserted.
        bus.REQ = 4'b1111;
        bus.X   = 4'b1111;
        rst     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_gnt",   32'(bus.GNT),   32'h0);
            chk("rst_det",   32'(bus.DET),   32'h0);
            chk("rst_busy",  32'(bus.BUSY),  32'h0);
            chk("rst_owner", 32'(bus.OWNER), 32'h0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt",   32'(bus.GNT),   32'h1);
        chk("first_owner", 32'(bus.OWNER), 32'h0);
        chk("first_busy",  32'(bus.BUSY),  32'h1);
        bus.REQ = 4'b0000;
        tick();
        chk("flush_gnt",  32'(bus.GNT),  32'h0);
        chk("flush_busy", 32'(bus.BUSY), 32'h1);
        tick();
        chk("idle_busy",  32'(bus.BUSY), 32'h0);

        // Single detect on requester 0: 1,1,1,1,0.
        bus.REQ = 4'b0001;
        bus.X   = 4'b0000;
        tick();
        chk("sd_gnt", 32'(bus.GNT), 32'h1);
        xs = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        ds = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        for (int s = 0; s < 5; s++) begin
            bus.X = xs[s];
            tick();
            chk($sformatf("sd_det%0d", s), 32'(bus.DET), 32'(ds[s]));
        end
        release_all();
        chk("sd_end_gnt", 32'(bus.GNT), 32'h0);

        // Broken run: 1,1,0,1,1,1 with other lanes held high.
        bus.REQ = 4'b0001;
        tick();
        chk("br_gnt", 32'(bus.GNT), 32'h1);
        xs = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
        ds = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int s = 0; s < 6; s++) begin
            bus.X = xs[s];
            tick();
            chk($sformatf("br_det%0d", s), 32'(bus.DET), 32'(ds[s]));
        end
        release_all();

        // Rotation with all requesting; each owner drops REQ after 2 cycles.
        do_reset();
        bus.REQ = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rot_gnt%0d", k),   32'(bus.GNT),   32'(1 << (k % 4)));
            chk($sformatf("rot_owner%0d", k), 32'(bus.OWNER), 32'(k % 4));
            tick();
            tick();
            bus.REQ[k % 4] = 1'b0;
            tick();
            chk($sformatf("rot_gap1_%0d", k), 32'(bus.GNT), 32'h0);
            bus.REQ[k % 4] = 1'b1;
            tick();
            chk($sformatf("rot_gap2_%0d", k), 32'(bus.GNT), 32'h0);
            tick();
        end
        chk("rot_gnt5", 32'(bus.GNT), 32'h2);
        release_all();

        // Burst: requesters 1 and 2 hold REQ with X all ones.
        do_reset();
        bus.REQ = 4'b0110;
        bus.X   = 4'b1111;
        tick();
        chk("bu_gnt0", 32'(bus.GNT), 32'h2);
        for (int s = 1; s <= 16; s++) begin
            tick();
`ifdef ARB_BURST_LIMIT_EN
            if (s == 16) begin
                chk("bu_flush_gnt",  32'(bus.GNT),  32'h0);
                chk("bu_flush_det",  32'(bus.DET),  32'h0);
                chk("bu_flush_busy", 32'(bus.BUSY), 32'h1);
            end else begin
                chk($sformatf("bu_gnt%0d", s), 32'(bus.GNT), 32'h2);
                chk($sformatf("bu_det%0d", s), 32'(bus.DET), (s >= 3) ? 32'h2 : 32'h0);
            end
`else
            chk($sformatf("bu_gnt%0d", s), 32'(bus.GNT), 32'h2);
            chk($sformatf("bu_det%0d", s), 32'(bus.DET), (s >= 3) ? 32'h2 : 32'h0);
`endif
        end
`ifdef ARB_BURST_LIMIT_EN
        tick();
        chk("bu_idle_gnt", 32'(bus.GNT), 32'h0);
        tick();
        chk("bu_next_gnt", 32'(bus.GNT), 32'h4);
`else
        for (int s = 0; s < 8; s++) begin
            tick();
            chk($sformatf("bu_hold%0d", s), 32'(bus.GNT), 32'h2);
        end
        chk("bu_hold_det", 32'(bus.DET), 32'h2);
`endif
        release_all();

        // Reset mid-OWN: owner 2 with run=2, then re-grant.
        do_reset();
        bus.REQ = 4'b0100;
        bus.X   = 4'b1111;
        tick();
        chk("rm_gnt", 32'(bus.GNT), 32'h4);
        tick();
        tick();
        chk("rm_det_pre", 32'(bus.DET), 32'h0);
        rst = 1'b1;
        tick();
        chk("rm_rst_gnt",   32'(bus.GNT),   32'h0);
        chk("rm_rst_det",   32'(bus.DET),   32'h0);
        chk("rm_rst_busy",  32'(bus.BUSY),  32'h0);
        chk("rm_rst_owner", 32'(bus.OWNER), 32'h0);
        rst = 1'b0;
        tick();
        chk("rm_regnt", 32'(bus.GNT), 32'h4);
        tick();
        chk("rm_det1", 32'(bus.DET), 32'h0);
        tick();
        chk("rm_det2", 32'(bus.DET), 32'h0);
        tick();
        chk("rm_det3", 32'(bus.DET), 32'h4);
        release_all();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
